reg_readback: RTL and testbench
===============================

# reg_readback

Sequential reader for the processor's register bank. On a start pulse it walks a contiguous range of bank entries, issuing one synchronous read per entry and presenting each word on a valid/ready output stream. The last word is flagged, and a one-cycle done pulse follows it. It sits between the register bank's read port and the debug/readback path, so bank contents can be dumped without stalling the datapath's own write port.

## Interface
Parameters:
- N, 24: data width of a bank entry and of out_data.
- NREGS, 16: number of bank entries; must be ≥ 2.
- ADDR_W, $clog2(NREGS): bank address width (derived; not overridden).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a readback; sampled only in IDLE.
- base_addr  in  ADDR_W  first entry to read; latched at start.
- count  in  ADDR_W+1  number of entries to read; latched at start.
- rd_en  out  1  bank read strobe.
- rd_addr  out  ADDR_W  bank read address.
- rd_data  in  N  bank read data; valid the cycle after rd_en (1-cycle latency).
- out_data  out  N  current word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word.
- out_last  out  1  current word is the final one of the burst.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse after the last handshake.

## Operation
- States: IDLE, ISSUE, CAPTURE, PRESENT, DONE.
- IDLE:
  - start=1 latches base_addr into ptr and count into remaining.
  - If count=0, go to DONE (no reads).
  - Otherwise go to ISSUE.
  - Count values above NREGS clamp to NREGS.
- ISSUE: rd_en=1, rd_addr=ptr. Go to CAPTURE.
- CAPTURE: at the edge, out_data<=rd_data, out_valid<=1, out_last<=(remaining==1). Go to PRESENT.
- PRESENT:
  - Hold out_data, out_valid and out_last stable until out_valid&&out_ready.
  - On handshake: out_valid<=0, remaining decrements, and ptr<=ptr+1 (wraps modulo NREGS, not modulo 2^ADDR_W).
  - If remaining was 1, go to DONE; else go to ISSUE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored; base_addr and count changes after the latch have no effect.
- rd_en is 0 in every state except ISSUE; rd_addr is 0 when rd_en=0.
- Reset at any point, including mid-burst:
  - Next state is IDLE.
  - out_data, out_valid, out_last, rd_en, rd_addr, done and busy are all 0 after the reset edge.
  - Any pending word is discarded.

## Timing
- Reset values: every output 0; internal ptr and remaining are 0.
- Edge E0 samples start in IDLE, with count ≥ 1:
  - Cycle after E0: rd_en=1, rd_addr=base.
  - After E1: state CAPTURE.
  - After E2: out_valid=1 (first-word latency is 2 edges).
- With out_ready held high, throughput is one word per 3 cycles (ISSUE, CAPTURE, PRESENT).
- Last handshake at edge Eh:
  - Cycle after Eh: done=1, out_valid=0.
  - Cycle after Eh+1: busy=0, and start is accepted again.
- count=0: done=1 in the cycle after E0, and rd_en is never asserted.
- busy is a combinational decode of the state register. All other outputs come from registers or from the state decode; no input-to-output combinational path exists except none.

## Configuration
- READBACK_PARITY_EN defined:
  - Adds port out_par (out, 1), the even parity of out_data. It is registered alongside out_data and holds its value under backpressure.
  - out_par resets to 0.
- READBACK_PARITY_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package readback_pkg holds:
  - typedef enum logic [2:0] rb_state_t {IDLE, ISSUE, CAPTURE, PRESENT, DONE}.
  - localparam RB_DATA_W = 24 (default for N).
- One sub-module, readback_parity: combinational N-bit XOR reduction, instantiated only under READBACK_PARITY_EN.
- All other logic lives in reg_readback: the FSM, the ptr/remaining counters and the output register.

## Test plan
- Reset mid-burst: assert rst while in PRESENT. Required response:
  - All outputs 0 after the reset edge.
  - A new start with base=3, count=1 then returns bank[3] with out_last=1.
- Basic burst, out_ready=1: base=2, count=3, bank[i]=24'h0A0000+i. Required response:
  - Words 0A0002, 0A0003, 0A0004 are delivered.
  - out_last is set on 0A0004.
  - done pulses once.
  - rd_en is asserted exactly 3 times.
- Wrap-around: NREGS=16, base=14, count=4. Required response: addresses 14, 15, 0, 1.
- Backpressure: out_ready=0 for 5 cycles during PRESENT. Required response:
  - out_data and out_valid are stable.
  - rd_en stays 0.
  - When ready rises, the handshake occurs on that edge.
- count=0 and count=20 (NREGS=16):
  - count=0: done follows E0 with no reads.
  - count=20: exactly 16 words are delivered.
- start pulsed during a busy burst: the request is ignored, and the burst completes with its original base and count.

Source files
------------

// File: rtl/readback_pkg.sv
// -----------------------------------------------------------------------------
// readback_pkg
// Shared types and defaults for the register-bank readback engine.
//   rb_state_t : readback FSM state encoding
//   RB_DATA_W  : default bank word width
// -----------------------------------------------------------------------------
package readback_pkg;

   localparam int RB_DATA_W = 24;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      CAPTURE = 3'd2,
      PRESENT = 3'd3,
      DONE    = 3'd4
   } rb_state_t;

endpackage : readback_pkg

// File: rtl/readback_parity.sv
// -----------------------------------------------------------------------------
// readback_parity
// Even parity of one bank word (XOR reduction). Purely combinational.
// Ports:
//   data_i  in  N  word to protect
//   par_o   out 1  XOR of all bits of data_i
// -----------------------------------------------------------------------------
module readback_parity #(
   parameter int N = 24
) (
   input  logic [N-1:0] data_i,
   output logic         par_o
);

   assign par_o = ^data_i;

endmodule : readback_parity

// File: rtl/reg_readback.sv
// -----------------------------------------------------------------------------
// reg_readback
// Walks a contiguous range of register-bank entries and streams each word out
// on a valid/ready interface. One read per entry, final word flagged with
// out_last, followed by a one-cycle done pulse.
//
// Optional feature: define READBACK_PARITY_EN to add out_par, the even parity
// of out_data, registered together with the data word.
//
// Ports:
//   clk        in   1         rising-edge clock
//   rst        in   1         synchronous active-high reset
//   start      in   1         begin a readback (honoured only when idle)
//   base_addr  in   ADDR_W    first entry, latched at start
//   count      in   ADDR_W+1  number of entries, latched at start
//   rd_en      out  1         bank read strobe
//   rd_addr    out  ADDR_W    bank read address (0 when rd_en is low)
//   rd_data    in   N         bank data, one cycle after rd_en
//   out_data   out  N         current word
//   out_valid  out  1         out_data is valid
//   out_ready  in   1         consumer accepts the word
//   out_last   out  1         current word is the final one
//   busy       out  1         engine is not idle
//   done       out  1         one-cycle pulse after the final handshake
//   out_par    out  1         parity of out_data (READBACK_PARITY_EN only)
// -----------------------------------------------------------------------------
module reg_readback
   import readback_pkg::*;
#(
   parameter int N      = RB_DATA_W,
   parameter int NREGS  = 16,
   // Derived from NREGS; leave at its default.
   parameter int ADDR_W = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   count,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [N-1:0]      rd_data,
   output logic [N-1:0]      out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done
`ifdef READBACK_PARITY_EN
   ,
   output logic              out_par
`endif
);

   localparam logic [ADDR_W:0]   MAX_CNT  = (ADDR_W+1)'(NREGS);
   localparam logic [ADDR_W:0]   ONE_CNT  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NREGS - 1);

   rb_state_t         state_q, state_d;
   logic [ADDR_W-1:0] ptr_q,   ptr_d;
   logic [ADDR_W:0]   rem_q,   rem_d;
   logic [N-1:0]      data_q,  data_d;
   logic              valid_q, valid_d;
   logic              last_q,  last_d;

   logic              handshake;

   assign handshake = valid_q && out_ready;

   // NOTE: every signal assigned in an always_comb gets a default first, so
   // no path through the case statement leaves one unassigned (no latches).
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               ptr_d   = base_addr;
               // A burst never reads more than the whole bank.
               rem_d   = (count > MAX_CNT) ? MAX_CNT : count;
               state_d = (count == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            data_d  = rd_data;
            valid_d = 1'b1;
            last_d  = (rem_q == ONE_CNT);
            state_d = PRESENT;
         end
         PRESENT: begin
            if (handshake) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               rem_d   = rem_q - ONE_CNT;
               // Wrap at the bank size, which need not be a power of two.
               ptr_d   = (ptr_q == LAST_PTR) ? '0 : ptr_q + ADDR_W'(1);
               state_d = (rem_q == ONE_CNT) ? DONE : ISSUE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so all
   // registers see the pre-edge values of each other.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   // Read strobe and address are decodes of registered state only, so the
   // bank port never sees a combinational path from the stream inputs.
   assign rd_en   = (state_q == ISSUE);
   assign rd_addr = rd_en ? ptr_q : '0;

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign out_last  = last_q;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);

`ifdef READBACK_PARITY_EN
   logic par_next;
   logic par_q;

   readback_parity #(.N(N)) u_parity (
      .data_i (rd_data),
      .par_o  (par_next)
   );

   // Captured on the same edge as out_data, so it tracks the held word.
   always_ff @(posedge clk) begin
      if (rst) begin
         par_q <= 1'b0;
      end else if (state_q == CAPTURE) begin
         par_q <= par_next;
      end
   end

   assign out_par = par_q;
`endif

endmodule : reg_readback

// File: tb/tb_reg_readback.sv
// -----------------------------------------------------------------------------
// tb_reg_readback
// Self-checking bench for reg_readback (N=24, NREGS=16). A behavioural bank
// answers reads with one cycle of latency; expected streams are computed as
// bank[(base+i) % NREGS] for i < min(count, NREGS).
// -----------------------------------------------------------------------------
module tb_reg_readback;

   localparam int N     = 24;
   localparam int NREGS = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   count;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [N-1:0]  rd_data;
   logic [N-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          busy;
   logic          done;
`ifdef READBACK_PARITY_EN
   logic          out_par;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [N-1:0] bank [NREGS];
   int           rd_cnt;
   int           rd_q[$];

   always #5 clk = ~clk;

   reg_readback #(.N(N), .NREGS(NREGS)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .count     (count),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
`ifdef READBACK_PARITY_EN
      ,
      .out_par   (out_par)
`endif
   );

   // Bank model: one-cycle read latency.
   always @(posedge clk) begin
      if (rd_en) rd_data <= bank[rd_addr];
   end

   // Read-port monitor: records every read and checks idle address is 0.
   always @(negedge clk) begin
      n_cmp++;
      if (!rd_en && rd_addr !== '0) begin
         n_err++;
         $display("FAIL rd_addr_idle: got %0d expected 0", rd_addr);
      end
      if (rd_en === 1'b1) begin
         rd_cnt++;
         rd_q.push_back(int'(rd_addr));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic randomize_bank();
      for (int i = 0; i < NREGS; i++) bank[i] = N'($urandom);
   endtask

   task automatic check_all_zero(input string name);
      cmp({name, "_rd_en"},     64'(rd_en),     64'd0);
      cmp({name, "_rd_addr"},   64'(rd_addr),   64'd0);
      cmp({name, "_out_data"},  64'(out_data),  64'd0);
      cmp({name, "_out_valid"}, 64'(out_valid), 64'd0);
      cmp({name, "_out_last"},  64'(out_last),  64'd0);
      cmp({name, "_busy"},      64'(busy),      64'd0);
      cmp({name, "_done"},      64'(done),      64'd0);
`ifdef READBACK_PARITY_EN
      cmp({name, "_out_par"},   64'(out_par),   64'd0);
`endif
   endtask

   // Generic burst: drives start, consumes the stream and compares it with
   // the address-range model. rnd_ready randomises out_ready; poke_start
   // pulses start with different arguments after the first word.
   task automatic run_burst(input string name, input int base, input int cnt,
                            input bit rnd_ready, input bit poke_start);
      logic [N-1:0] exp_q[$];
      logic [N-1:0] got_q[$];
      bit           last_q[$];
      int           n;
      int           since;
      int           dones;
      bit           prev_valid;
      logic [N-1:0] prev_data;
      bit           drained;

      n = (cnt > NREGS) ? NREGS : cnt;
      for (int i = 0; i < n; i++) exp_q.push_back(bank[(base + i) % NREGS]);

      @(negedge clk);
      rd_cnt    = 0;
      rd_q.delete();
      start     = 1'b1;
      base_addr = AW'(base);
      count     = (AW+1)'(cnt);
      out_ready = 1'b0;
      since      = (n == 0) ? 0 : -1;
      dones      = 0;
      prev_valid = 1'b0;
      prev_data  = '0;
      drained    = 1'b0;

      for (int cyc = 0; cyc < 400 && !drained; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (poke_start && got_q.size() == 1) begin
            start     = 1'b1;
            base_addr = AW'(base + 5);
            count     = (AW+1)'(2);
         end
         if (done === 1'b1) dones++;
         if (since >= 0) since++;
         if (since == 1) begin
            cmp({name, "_done_after_last"}, 64'(done), 64'd1);
            cmp({name, "_valid_after_last"}, 64'(out_valid), 64'd0);
         end
         if (since == 2) begin
            cmp({name, "_busy_idle"}, 64'(busy), 64'd0);
            cmp({name, "_done_single"}, 64'(done), 64'd0);
            drained = 1'b1;
         end
         if (prev_valid) begin
            cmp({name, "_hold_valid"}, 64'(out_valid), 64'd1);
            cmp({name, "_hold_data"}, 64'(out_data), 64'(prev_data));
         end
         if (out_valid === 1'b1) cmp({name, "_no_read_while_present"}, 64'(rd_en), 64'd0);

         out_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (out_valid === 1'b1 && out_ready) begin
            got_q.push_back(out_data);
            last_q.push_back(out_last);
`ifdef READBACK_PARITY_EN
            cmp({name, "_parity"}, 64'(out_par), 64'(^out_data));
`endif
            if (got_q.size() == n) since = 0;
            prev_valid = 1'b0;
         end else begin
            prev_valid = (out_valid === 1'b1);
            prev_data  = out_data;
         end
      end
      start     = 1'b0;
      out_ready = 1'b0;

      cmp({name, "_drained"}, 64'(drained), 64'd1);
      cmp({name, "_word_count"}, 64'(got_q.size()), 64'(n));
      for (int i = 0; i < n && i < got_q.size(); i++) begin
         cmp({name, "_word"}, 64'(got_q[i]), 64'(exp_q[i]));
         cmp({name, "_last"}, 64'(last_q[i]), 64'(i == n - 1));
      end
      cmp({name, "_reads"}, 64'(rd_cnt), 64'(n));
      for (int i = 0; i < n && i < rd_q.size(); i++)
         cmp({name, "_read_addr"}, 64'(rd_q[i]), 64'((base + i) % NREGS));
      cmp({name, "_done_pulses"}, 64'(dones), 64'd1);
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      count     = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
   endtask

   task automatic test_latency();
      randomize_bank();
      @(negedge clk);
      start     = 1'b1;
      base_addr = AW'(5);
      count     = (AW+1)'(2);
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cmp("lat_issue_rd_en",   64'(rd_en),     64'd1);
      cmp("lat_issue_rd_addr", 64'(rd_addr),   64'd5);
      cmp("lat_issue_busy",    64'(busy),      64'd1);
      cmp("lat_issue_valid",   64'(out_valid), 64'd0);
      @(negedge clk);
      cmp("lat_capture_rd_en", 64'(rd_en),     64'd0);
      cmp("lat_capture_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      cmp("lat_w0_valid", 64'(out_valid), 64'd1);
      cmp("lat_w0_data",  64'(out_data),  64'(bank[5]));
      cmp("lat_w0_last",  64'(out_last),  64'd0);
      @(negedge clk);
      cmp("lat_w1_issue", 64'(rd_en),   64'd1);
      cmp("lat_w1_addr",  64'(rd_addr), 64'd6);
      @(negedge clk);
      cmp("lat_w1_capture_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      cmp("lat_w1_valid", 64'(out_valid), 64'd1);
      cmp("lat_w1_data",  64'(out_data),  64'(bank[6]));
      cmp("lat_w1_last",  64'(out_last),  64'd1);
      @(negedge clk);
      cmp("lat_done",      64'(done),      64'd1);
      cmp("lat_done_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      cmp("lat_idle_busy", 64'(busy), 64'd0);
      cmp("lat_idle_done", 64'(done), 64'd0);
      out_ready = 1'b0;
   endtask

   task automatic test_basic();
      for (int i = 0; i < NREGS; i++) bank[i] = 24'h0A0000 + N'(i);
      run_burst("basic", 2, 3, 1'b0, 1'b0);
   endtask

   task automatic test_wrap();
      randomize_bank();
      run_burst("wrap", 14, 4, 1'b0, 1'b0);
   endtask

   task automatic test_backpressure();
      logic [N-1:0] held;
      int           k;
      randomize_bank();
      @(negedge clk);
      start     = 1'b1;
      base_addr = AW'(7);
      count     = (AW+1)'(2);
      out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (out_valid !== 1'b1 && k < 10) begin
         @(negedge clk);
         k++;
      end
      cmp("bp_first_valid", 64'(out_valid), 64'd1);
      held = out_data;
      cmp("bp_first_data", 64'(held), 64'(bank[7]));
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         cmp("bp_stable_valid", 64'(out_valid), 64'd1);
         cmp("bp_stable_data",  64'(out_data),  64'(held));
         cmp("bp_no_read",      64'(rd_en),     64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      cmp("bp_handshake_valid", 64'(out_valid), 64'd0);
      cmp("bp_next_issue",      64'(rd_en),     64'd1);
      cmp("bp_next_addr",       64'(rd_addr),   64'd8);
      k = 0;
      while (busy !== 1'b0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      cmp("bp_drain", 64'(busy), 64'd0);
      out_ready = 1'b0;
   endtask

   task automatic test_count_edges();
      randomize_bank();
      run_burst("count0", 9, 0, 1'b0, 1'b0);
      randomize_bank();
      run_burst("count20", 5, 20, 1'b1, 1'b0);
   endtask

   task automatic test_start_while_busy();
      randomize_bank();
      run_burst("busy_start", 10, 4, 1'b1, 1'b1);
   endtask

   task automatic test_random_bursts();
      for (int t = 0; t < 4; t++) begin
         randomize_bank();
         run_burst("random", $urandom_range(0, NREGS - 1), $urandom_range(1, 31), 1'b1, 1'b0);
      end
   endtask

   task automatic test_reset_mid_burst();
      int k;
      randomize_bank();
      @(negedge clk);
      start     = 1'b1;
      base_addr = AW'(4);
      count     = (AW+1)'(5);
      out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (out_valid !== 1'b1 && k < 10) begin
         @(negedge clk);
         k++;
      end
      cmp("midrst_reached_present", 64'(out_valid), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("midrst");
      rst = 1'b0;
      run_burst("after_reset", 3, 1, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_latency();
      test_basic();
      test_wrap();
      test_backpressure();
      test_count_edges();
      test_start_while_busy();
      test_random_bursts();
      test_reset_mid_burst();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_reg_readback
